mem_step_bridge: RTL and testbench

Sits directly downstream of the multi-cycle CPU core. It converts the core's byte-addressed, size-tagged bus (address, data_out, write_enable, data_size) into accesses on a word-wide synchronous block RAM with byte enables. It returns zero-extended read data on data_in and paces the core through enable_step. It splits unaligned accesses that straddle a word boundary into two RAM accesses, flags out-of-range accesses, and supports free-run or single-step operation.

---
 rtl/mem_bridge_pkg.sv | 10 +
 rtl/mem_step_bridge_lane_align.sv | 21 ++
 rtl/mem_step_bridge.sv | 98 +++++++++
 tb/tb_mem_step_bridge.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared state type, size codes and size decode for the memory step bridge
package mem_bridge_pkg;
  typedef enum logic [1:0] {ACCEPT, FIRST, SECOND, DONE} bridge_state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  function automatic logic [2:0] size_bytes(input logic [1:0] ds);
    return ds >= SZ_WORD ? 3'd4 : ds == SZ_BYTE ? 3'd1 : 3'd2;
  endfunction
endpackage

// File: rtl/mem_step_bridge_lane_align.sv
// lane_align: little-endian byte-lane placement of an access across a word pair
module lane_align (
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_n,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be0,
  output logic [3:0]  o_be1,
  output logic [31:0] o_d0,
  output logic [31:0] o_d1,
  output logic        o_cross
);
  logic [7:0]  w_be;
  logic [63:0] w_d;
  assign w_be    = ((8'd1 << i_n) - 8'd1) << i_off;
  assign w_d     = {32'b0, i_wdata} << {i_off, 3'b0};
  assign o_be0   = w_be[3:0];
  assign o_be1   = w_be[7:4];
  assign o_d0    = w_d[31:0];
  assign o_d1    = w_d[63:32];
  assign o_cross = |w_be[7:4];
endmodule

// File: rtl/mem_step_bridge.sv
// mem_step_bridge: byte-addressed core bus to word-wide byte-enable RAM with step pacing
module mem_step_bridge
  import mem_bridge_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   address,
  input  logic [31:0]   data_out,
  input  logic          write_enable,
  input  logic [1:0]    data_size,
  input  logic          run,
  input  logic          step,
  output logic [31:0]   data_in,
  output logic          enable_step,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [31:0]   mem_rdata,
  output logic          fault,
  output logic [31:0]   fault_addr
);
  localparam int MEM_BYTES = 4 * MEM_WORDS;
  bridge_state_t r_state;
  logic [1:0]    r_off;
  logic [AW-1:0] r_w0;
  logic [2:0]    r_n;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic          w_acc, w_oor, w_go0, w_go1, w_cross;
  logic [2:0]    w_n_in;
  logic [3:0]    w_be0, w_be1;
  logic [31:0]   w_d0, w_d1, w_mask;
  logic [5:0]    w_sh1;
  assign w_acc  = r_state == ACCEPT;
  assign w_n_in = size_bytes(data_size);
  assign w_oor  = {1'b0, address} + 33'(w_n_in) > 33'(MEM_BYTES);
  // One aligner serves both halves: live inputs while accepting, latched access afterwards
  lane_align u_align (
    .i_off   (w_acc ? address[1:0] : r_off),
    .i_n     (w_acc ? w_n_in : r_n),
    .i_wdata (w_acc ? data_out : r_wdata),
    .o_be0   (w_be0),
    .o_be1   (w_be1),
    .o_d0    (w_d0),
    .o_d1    (w_d1),
    .o_cross (w_cross)
  );
  // RAM port is driven combinationally so the synchronous RAM samples it at the end of the same cycle
  assign w_go0       = !rst && w_acc && !w_oor;
  assign w_go1       = !rst && r_state == FIRST && w_cross;
  assign mem_addr    = w_go0 ? address[AW+1:2] : w_go1 ? r_w0 + 1'b1 : '0;
  assign mem_be      = w_go0 && write_enable ? w_be0 : w_go1 && r_we ? w_be1 : '0;
  assign mem_wdata   = w_go0 && write_enable ? w_d0 : w_go1 && r_we ? w_d1 : '0;
  assign enable_step = !rst && r_state == DONE && (run || step);
  assign w_mask      = r_n == 3'd4 ? 32'hFFFF_FFFF : r_n == 3'd2 ? 32'h0000_FFFF : 32'h0000_00FF;
  assign w_sh1       = {3'd4 - {1'b0, r_off}, 3'b0};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ACCEPT;
      r_off      <= '0;
      r_w0       <= '0;
      r_n        <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      data_in    <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      case (r_state)
        ACCEPT: begin
          r_off   <= address[1:0];
          r_w0    <= address[AW+1:2];
          r_n     <= w_n_in;
          r_we    <= write_enable;
          r_wdata <= data_out;
          r_state <= w_oor ? DONE : FIRST;
          if (w_oor) data_in <= '0;
          if (w_oor && !fault) begin
            fault      <= 1'b1;
            fault_addr <= address;
          end
        end
        FIRST: begin
          if (!r_we) data_in <= (mem_rdata >> {r_off, 3'b0}) & w_mask;
          r_state <= w_cross ? SECOND : DONE;
        end
        SECOND: begin
          if (!r_we) data_in <= data_in | ((mem_rdata << w_sh1) & w_mask);
          r_state <= DONE;
        end
        DONE: r_state <= (run || step) ? ACCEPT : DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_step_bridge.sv
// tb_mem_step_bridge: directed vector table, corner sequences and randomized model check of mem_step_bridge
module tb_mem_step_bridge;
  import mem_bridge_pkg::*;
  localparam int MW = 4;
  logic        clk = 0, rst = 1;
  logic [31:0] address = 0, data_out = 0;
  logic        write_enable = 0, run = 1, step = 0;
  logic [1:0]  data_size = 0;
  logic [31:0] data_in, mem_wdata, fault_addr;
  logic        enable_step, fault;
  logic [1:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  always #5 clk = ~clk;
  mem_step_bridge #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .address(address), .data_out(data_out),
    .write_enable(write_enable), .data_size(data_size), .run(run), .step(step),
    .data_in(data_in), .enable_step(enable_step), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .fault(fault), .fault_addr(fault_addr)
  );
  logic [31:0] ram [MW];
  logic        bd_we = 0;
  logic [1:0]  bd_addr = 0;
  logic [31:0] bd_data = 0;
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else for (int i = 0; i < 4; i++) if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= ram[mem_addr];
  end
  typedef struct {logic [1:0] a; logic [3:0] be; logic [31:0] d;} wr_t;
  wr_t wlog[$];
  always @(negedge clk) if (mem_be != 0) wlog.push_back(wr_t'{mem_addr, mem_be, mem_wdata});
  typedef struct {logic [31:0] a; logic [31:0] d; logic w; logic [1:0] s; logic [31:0] exp_d; int lat; logic f; logic [31:0] fa;} vec_t;
  vec_t tab[11];
  logic [7:0] rm [4*MW];
  int total = 0, bad = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic preload(input int idx, input logic [31:0] v);
    bd_addr = 2'(idx);
    bd_data = v;
    bd_we = 1;
    @(posedge clk); #1;
    bd_we = 0;
    for (int i = 0; i < 4; i++) rm[4*idx+i] = v[8*i +: 8];
  endtask
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [1:0] s, output int lat);
    address = a;
    data_out = d;
    write_enable = w;
    data_size = s;
    lat = 0;
    forever begin
      @(negedge clk);
      if (enable_step || lat > 8) break;
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
  endtask
  task automatic check_reset_outputs(input string p);
    check({p, "_din"}, data_in, 0);
    check({p, "_en"}, enable_step, 0);
    check({p, "_be"}, mem_be, 0);
    check({p, "_maddr"}, mem_addr, 0);
    check({p, "_wdata"}, mem_wdata, 0);
    check({p, "_fault"}, fault, 0);
    check({p, "_faddr"}, fault_addr, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, cnt, n;
    logic [31:0] a, d, exp_din, efa;
    logic [1:0] s;
    logic w, ef, oor;
    rst = 1;
    preload(0, 32'h44332211);
    preload(1, 32'h88776655);
    preload(2, 32'hCCBBAA99);
    preload(3, 32'h10203040);
    check_reset_outputs("reset");
    rst = 0;
    tab[0]  = '{32'h0, 0, 0, SZ_WORD, 32'h44332211, 2, 0, 0};
    tab[1]  = '{32'h3, 0, 0, SZ_BYTE, 32'h00000044, 2, 0, 0};
    tab[2]  = '{32'h2, 0, 0, SZ_HALF, 32'h00004433, 2, 0, 0};
    tab[3]  = '{32'h6, 0, 0, SZ_WORD, 32'hAA998877, 3, 0, 0};
    tab[4]  = '{32'h7, 32'hBEEF, 1, SZ_HALF, 32'hAA998877, 3, 0, 0};
    tab[5]  = '{32'h4, 0, 0, SZ_WORD, 32'hEF776655, 2, 0, 0};
    tab[6]  = '{32'hE, 0, 0, SZ_WORD, 32'h0, 1, 1, 32'hE};
    tab[7]  = '{32'h20, 0, 0, SZ_BYTE, 32'h0, 1, 1, 32'hE};
    tab[8]  = '{32'hD, 0, 0, SZ_BYTE, 32'h00000030, 2, 1, 32'hE};
    tab[9]  = '{32'hE, 0, 0, SZ_HALF, 32'h00001020, 2, 1, 32'hE};
    tab[10] = '{32'hFFFFFFFF, 0, 0, 2'b11, 32'h0, 1, 1, 32'hE};
    for (int i = 0; i < 11; i++) begin
      access(tab[i].a, tab[i].d, tab[i].w, tab[i].s, lat);
      check($sformatf("v%0d_data", i), data_in, tab[i].exp_d);
      check($sformatf("v%0d_lat", i), lat, tab[i].lat);
      check($sformatf("v%0d_fault", i), fault, tab[i].f);
      check($sformatf("v%0d_faddr", i), fault_addr, tab[i].fa);
    end
    check("wlog_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("wr0", {30'(wlog[0].a), wlog[0].be, wlog[0].d[31:24]}, {30'd1, 4'b1000, 8'hEF});
      check("wr1", {30'(wlog[1].a), wlog[1].be, wlog[1].d[7:0]}, {30'd2, 4'b0001, 8'hBE});
    end
    wlog.delete();
    address = 32'h5;
    data_out = 32'h11223344;
    write_enable = 1;
    data_size = SZ_WORD;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("rst_first_be", mem_be, 0);
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    write_enable = 0;
    address = 0;
    run = 0;
    rst = 0;
    check("midrst_wcount", wlog.size(), 1);
    if (wlog.size() == 1) check("midrst_be", wlog[0].be, 4'b1110);
    check("midrst_ram1", ram[1], 32'h22334455);
    check("midrst_ram2", ram[2], 32'hCCBBAABE);
    repeat (2) begin @(posedge clk); #1; end
    cnt = 0;
    repeat (5) begin @(negedge clk); cnt += int'(enable_step); @(posedge clk); #1; end
    check("hold_no_step", cnt, 0);
    check("hold_data", data_in, 32'h44332211);
    step = 1;
    repeat (3) begin @(negedge clk); cnt += int'(enable_step); @(posedge clk); #1; end
    step = 0;
    repeat (6) begin @(negedge clk); cnt += int'(enable_step); @(posedge clk); #1; end
    check("step_once", cnt, 1);
    run = 1;
    for (int b = 0; b < 4; b++) begin
      rst = 1;
      for (int i = 0; i < MW; i++) preload(i, $urandom);
      rst = 0;
      exp_din = 0;
      ef = 0;
      efa = 0;
      for (int k = 0; k < 15; k++) begin
        a = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15) : $urandom_range(0, 19);
        s = 2'($urandom_range(0, 3));
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        n = (s == 0) ? 1 : (s == 1) ? 2 : 4;
        oor = ({32'b0, a} + 64'(n)) > 64'(4 * MW);
        access(a, d, w, s, lat);
        if (oor) begin
          exp_din = 0;
          if (!ef) begin ef = 1; efa = a; end
        end else if (w) begin
          for (int i = 0; i < n; i++) rm[int'(a) + i] = d[8*i +: 8];
        end else begin
          exp_din = 0;
          for (int i = 0; i < n; i++) exp_din[8*i +: 8] = rm[int'(a) + i];
        end
        check($sformatf("r%0d_%0d_data", b, k), data_in, exp_din);
        check($sformatf("r%0d_%0d_lat", b, k), lat, oor ? 1 : (int'(a[1:0]) + n > 4) ? 3 : 2);
        check($sformatf("r%0d_%0d_fault", b, k), fault, ef);
        check($sformatf("r%0d_%0d_faddr", b, k), fault_addr, efa);
      end
      for (int i = 0; i < MW; i++)
        check($sformatf("r%0d_ram%0d", b, i), ram[i], {rm[4*i+3], rm[4*i+2], rm[4*i+1], rm[4*i]});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
